ifetch_queue: RTL

Parametrised instruction-fetch stage with a prefetch queue between the synchronous instruction ROM and decode. It sequences the PC, issues one ROM read per cycle when queue credit allows, buffers `{pc, inst}` pairs in a DEPTH-entry FIFO, and presents them to decode with a valid/ready handshake. Redirects (jump/branch) flush all buffered and in-flight work. A halt input (ecall) freezes fetch and output without losing state.

---
 rtl/ifetch_queue.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction-fetch stage with a prefetch queue between the synchronous
// instruction ROM and decode. It sequences the PC and issues at most one ROM
// read per cycle, when queue credit allows. It buffers {pc, inst} pairs in a
// DEPTH-entry FIFO and presents the head entry to decode.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. The
// head entry transfers on any cycle where both are high. out_valid never
// depends on out_ready. imem_en may depend on out_ready combinationally,
// because a pop in this cycle frees credit for an issue in this cycle.
//
// Optional feature macro: IFETCH_MISALIGN_EN
//   defined   : a redirect to a non-word-aligned target flushes the queue and
//               enters FAULT. FAULT does not issue, holds out_valid=0 and
//               keeps fetch_fault=1 (sticky). FAULT is left only by an
//               aligned redirect or by reset.
//   undefined : redirect_target[1:0] is ignored and fetch_fault is tied 0.
//
// Parameters:
//   DEPTH    - queue entries (power of two, >= 2)
//   RESET_PC - fetch PC after reset (word aligned)
//   IMEM_AW  - ROM word-address width
//
// Ports:
//   clk, rst           - clock; asynchronous active-low reset
//   redirect/_target   - flush all work and restart fetch at the target
//   halt               - level; freezes issue and output while high
//   imem_en/imem_addr  - ROM read request (word address)
//   imem_rdata         - ROM data, valid the cycle after imem_en
//   out_valid/out_ready- decode handshake
//   out_pc/out_inst    - head entry; both read 0 while out_valid=0
//   fetch_fault        - misaligned-redirect fault flag
//   mode_dbg           - registered mode (0=RUN, 1=HALT, 2=FAULT)
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  input  logic               halt,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_inst,
  output logic               fetch_fault,
  output logic [1:0]         mode_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    M_RUN   = 2'd0,
    M_HALT  = 2'd1,
    M_FAULT = 2'd2
  } mode_e;

  mode_e          mode_q, mode_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic           req_valid_q, req_valid_d;
  logic [31:0]    req_pc_q, req_pc_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    mem_pc_q   [DEPTH];
  logic [31:0]    mem_pc_d   [DEPTH];
  logic [31:0]    mem_inst_q [DEPTH];
  logic [31:0]    mem_inst_d [DEPTH];

  logic           run_en;
  logic           deq;
  logic           push;
  logic           misalign;
  logic [CW:0]    occ;

  always_comb begin
    // Halt acts in the same cycle it is raised. The mode register only
    // records it, so issue and output track the level directly.
    run_en = (mode_q != M_FAULT) & ~halt;

`ifdef IFETCH_MISALIGN_EN
    misalign = (redirect_target[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif

    out_valid = (count_q != '0) & run_en;
    deq       = out_valid & out_ready;
    push      = req_valid_q & ~redirect;

    // Credit: queued entries plus the read in flight, minus this cycle's pop,
    // must leave room for one more response.
    occ     = {1'b0, count_q} + (CW+1)'(req_valid_q) - (CW+1)'(deq);
    // The rst term keeps the ROM quiet while reset is held.
    imem_en = rst & run_en & ~redirect & (occ < DEPTH_W);

    imem_addr = fetch_pc_q[IMEM_AW+1:2];
    out_pc    = out_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
    out_inst  = out_valid ? mem_inst_q[rd_ptr_q] : 32'h0;
`ifdef IFETCH_MISALIGN_EN
    fetch_fault = (mode_q == M_FAULT);
`else
    fetch_fault = 1'b0;
`endif
    mode_dbg = mode_q;

    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_pc_d    = mem_pc_q;
    mem_inst_d  = mem_inst_q;

    if (imem_en) begin
      req_valid_d = 1'b1;
      req_pc_d    = fetch_pc_q;
      fetch_pc_d  = fetch_pc_q + 32'd4;
    end

    if (push) begin
      mem_pc_d[wr_ptr_q]   = req_pc_q;
      mem_inst_d[wr_ptr_q] = imem_rdata;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end

    if (deq) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(deq);

    // Redirect wins over everything else. The in-flight word is dropped
    // because push is already masked above.
    if (redirect) begin
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      req_valid_d = 1'b0;
      fetch_pc_d  = redirect_target & 32'hFFFF_FFFC;
    end

    mode_d = halt ? M_HALT : M_RUN;
    if (mode_q == M_FAULT) begin
      if (!(redirect && !misalign)) begin
        mode_d = M_FAULT;
      end
    end else if (redirect && misalign) begin
      mode_d = M_FAULT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q      <= M_RUN;
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= 32'h0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= 32'h0;
        mem_inst_q[i] <= 32'h0;
      end
    end else begin
      mode_q      <= mode_d;
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= mem_pc_d[i];
        mem_inst_q[i] <= mem_inst_d[i];
      end
    end
  end

endmodule
